// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image from the debug UART,
// writes it word-by-word into CPU memory while holding the CPU in reset,
// answers the host with ACK/NAK and then releases (or keeps holding) the CPU.
module uart_boot_loader #(
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 1200000,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              load_error
);

  localparam logic [7:0]       SYNC      = 8'hA5;
  localparam logic [7:0]       ACK       = 8'h06;
  localparam logic [7:0]       NAK       = 8'h15;
  localparam int               GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT - 2);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } state_t;

  state_t            state;
  logic              init_done;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [ADDR_W:0]   idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_word;
  logic [GAP_W-1:0]  gap;
  logic              tx_sent;
  logic              resp_ack;

  logic              frame_st;
  logic              timed_out;
  logic [15:0]       len_full;
  logic [16:0]       idx_next;

  // Gap timer only matters while a frame is being received; the edge on which
  // it reaches TIMEOUT-1 abandons the frame.
  assign frame_st  = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_DATA)   || (state == ST_CSUM);
  assign timed_out = frame_st && !rx_dv && (gap == GAP_LAST);
  assign len_full  = {rx_byte, len[7:0]};
  assign idx_next  = 17'(idx) + 17'd1;

  // Frame-receive FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      init_done  <= 1'b0;
      len        <= '0;
      csum       <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      asm_word   <= '0;
      gap        <= '0;
      tx_sent    <= 1'b0;
      resp_ack   <= 1'b0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_resetn <= 1'b0;
      busy       <= 1'b0;
      load_error <= 1'b0;
    end else begin
      tx_dv     <= 1'b0;
      mem_we    <= 1'b0;
      init_done <= 1'b1;

      if (rx_dv || !frame_st)
        gap <= '0;
      else
        gap <= gap + 1'b1;

      case (state)
        ST_IDLE, ST_RUN: begin
          if (rx_dv && rx_byte == SYNC) begin
            state      <= ST_LEN_LO;
            cpu_resetn <= 1'b0;
            load_error <= 1'b0;
            csum       <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            busy       <= 1'b1;
          end else if (state == ST_IDLE && !init_done && AUTO_RUN) begin
            state      <= ST_RUN;
            cpu_resetn <= 1'b1;
          end
        end

        ST_LEN_LO: begin
          if (rx_dv) begin
            len[7:0] <= rx_byte;
            csum     <= csum ^ rx_byte;
            state    <= ST_LEN_HI;
          end
        end

        ST_LEN_HI: begin
          if (rx_dv) begin
            len[15:8] <= rx_byte;
            csum      <= csum ^ rx_byte;
            if ({1'b0, len_full} > MAX_WORDS) begin
              state      <= ST_RESP;
              tx_byte    <= NAK;
              resp_ack   <= 1'b0;
              tx_sent    <= 1'b0;
              load_error <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end

        // Bytes arrive LSB first; after three shifts asm_word holds {b2,b1,b0}.
        ST_DATA: begin
          if (rx_dv) begin
            csum     <= csum ^ rx_byte;
            byte_cnt <= byte_cnt + 2'd1;
            asm_word <= {rx_byte, asm_word[23:8]};
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {rx_byte, asm_word};
              mem_addr  <= idx[ADDR_W-1:0];
              idx       <= idx + 1'b1;
              if (idx_next == {1'b0, len})
                state <= ST_CSUM;
            end
          end
        end

        ST_CSUM: begin
          if (rx_dv) begin
            state   <= ST_RESP;
            tx_sent <= 1'b0;
            if (rx_byte == csum) begin
              tx_byte  <= ACK;
              resp_ack <= 1'b1;
            end else begin
              tx_byte    <= NAK;
              resp_ack   <= 1'b0;
              load_error <= 1'b1;
            end
          end
        end

        ST_RESP: begin
          if (!tx_sent && !tx_active) begin
            tx_dv   <= 1'b1;
            tx_sent <= 1'b1;
          end else if (tx_sent && tx_done) begin
            busy    <= 1'b0;
            tx_sent <= 1'b0;
            if (resp_ack) begin
              state      <= ST_RUN;
              cpu_resetn <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (timed_out) begin
        state      <= ST_RESP;
        tx_byte    <= NAK;
        resp_ack   <= 1'b0;
        tx_sent    <= 1'b0;
        load_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: directed frames plus randomized frames,
// expected memory writes and response bytes queued by a frame-level model
// and consumed by an independent output monitor.
module tb_uart_boot_loader;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 50;
  localparam logic [7:0] ACK_B = 8'h06;
  localparam logic [7:0] NAK_B = 8'h15;

  logic              clk;
  logic              resetn;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              tx_active;
  logic              tx_done;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_resetn;
  logic              busy;
  logic              load_error;

  uart_boot_loader #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .AUTO_RUN(1'b1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_resetn(cpu_resetn),
    .busy      (busy),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [41:0] exp_mem [$];
  logic [7:0]  exp_tx  [$];
  logic [7:0]  frm     [$];
  bit          exp_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One rx_dv strobe; returns 1 time unit after the edge that sampled it.
  task automatic put(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_dv"},      tx_dv,      0);
    chk({tag, "_tx_byte"},    tx_byte,    0);
    chk({tag, "_mem_we"},     mem_we,     0);
    chk({tag, "_mem_addr"},   mem_addr,   0);
    chk({tag, "_mem_wdata"},  mem_wdata,  0);
    chk({tag, "_cpu_resetn"}, cpu_resetn, 0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_load_error"}, load_error, 0);
  endtask

  // Frame-level reference: decode the byte list in frm and queue the writes
  // and the response the loader must produce.
  task automatic model_push();
    int n;
    logic [7:0] x;
    n = {frm[2], frm[1]};
    if (n > (1 << ADDR_W)) begin
      exp_ok = 1'b0;
      exp_tx.push_back(NAK_B);
      return;
    end
    for (int i = 0; i < n; i++)
      exp_mem.push_back({i[ADDR_W-1:0], frm[3+4*i+3], frm[3+4*i+2],
                         frm[3+4*i+1], frm[3+4*i]});
    x = 8'h00;
    for (int j = 1; j < frm.size() - 1; j++) x = x ^ frm[j];
    exp_ok = (x == frm[frm.size()-1]);
    exp_tx.push_back(exp_ok ? ACK_B : NAK_B);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  task automatic send_frame(input string tag);
    model_push();
    for (int i = 0; i < frm.size(); i++) begin
      put(frm[i]);
      if (i == 0) begin
        chk({tag, "_sync_cpu_resetn"}, cpu_resetn, 0);
        chk({tag, "_sync_load_error"}, load_error, 0);
        chk({tag, "_sync_busy"},       busy,       1);
      end
      idle($urandom_range(0, 2));
    end
    wait_idle(tag);
    chk({tag, "_cpu_resetn"}, cpu_resetn, exp_ok);
    chk({tag, "_load_error"}, load_error, !exp_ok);
    chk({tag, "_mem_q_left"}, exp_mem.size(), 0);
    chk({tag, "_tx_q_left"},  exp_tx.size(),  0);
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    frm.delete();
    frm.push_back(8'hA5);
    b = n[7:0];  frm.push_back(b);
    b = n[15:8]; frm.push_back(b);
    x = n[7:0] ^ n[15:8];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      frm.push_back(b);
      x = x ^ b;
    end
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    frm.push_back(x);
  endtask

  // Minimal uart_tx stand-in: busy for a few cycles after each request.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (tx_dv && resetn) begin
        tx_active = 1'b1;
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk);
          #1;
        end
        tx_active = 1'b0;
        tx_done   = 1'b1;
      end
    end
  end

  // Output monitor: every write strobe and response request must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_we) begin
        if (exp_mem.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_mem_we: addr %0h data %0h with nothing expected", mem_addr, mem_wdata);
        end else begin
          chk("mem_write", {mem_addr, mem_wdata}, exp_mem.pop_front());
        end
      end
      if (tx_dv) begin
        if (exp_tx.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_tx_dv: byte %0h with nothing expected", tx_byte);
        end else begin
          chk("tx_byte", tx_byte, exp_tx.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    resetn  = 1'b0;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    idle(3);
    check_reset_vals("reset");
    resetn = 1'b1;
    chk("cpu_resetn_before_edge", cpu_resetn, 0);
    idle(1);
    chk("cpu_resetn_auto_run", cpu_resetn, 1);
    idle(3);

    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    send_frame("good2");

    frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame("badcs");

    put(8'h11);
    idle(3);
    chk("stray_busy",       busy,       0);
    chk("stray_load_error", load_error, 1);
    chk("stray_cpu_resetn", cpu_resetn, 0);

    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame("zero_len");

    frm = '{8'hA5, 8'h01, 8'h08};
    send_frame("oversize");

    exp_tx.push_back(NAK_B);
    put(8'hA5); put(8'h01); put(8'h00); put(8'h12); put(8'h34);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (tx_dv) break;
    end
    n_chk++;
    if (cnt >= TIMEOUT - 1 && cnt <= TIMEOUT + 1) n_pass++;
    else $display("FAIL timeout_latency: got %0d cycles expected %0d +-1", cnt, TIMEOUT);
    wait_idle("timeout");
    chk("timeout_load_error", load_error, 1);
    chk("timeout_cpu_resetn", cpu_resetn, 0);
    chk("timeout_tx_q_left",  exp_tx.size(), 0);

    put(8'hA5); put(8'h02); put(8'h00); put(8'hAA); put(8'hBB); put(8'hCC);
    resetn = 1'b0;
    idle(1);
    check_reset_vals("abort");
    idle(1);
    resetn = 1'b1;
    idle(6);
    chk("abort_cpu_resetn", cpu_resetn, 1);
    build(3, 1'b0);
    send_frame("after_abort");

    for (int f = 0; f < 8; f++) begin
      build($urandom_range(0, 6), ($urandom_range(0, 2) == 0));
      send_frame("rand");
    end

    idle(5);
    chk("final_mem_q", exp_mem.size(), 0);
    chk("final_tx_q",  exp_tx.size(),  0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
